dcache_flush_sequencer: RTL and testbench
=========================================

// Module: dcache_flush_sequencer
// PURPOSE
// Walks every set of the write-back data cache on a fence/flush request, writing back dirty
// lines and then clearing dirty bits or invalidating, per DcacheInvalidateOnFlush.
// Sits between the cache controller (flush_req/ack) and the tag/state RAM and writeback unit.
// Geometry parameters come from the derived core config (DCACHE_* fields).
// PARAMETERS
// NumSets            256  sets = 2**(DCACHE_INDEX_WIDTH-DCACHE_OFFSET_WIDTH); power of 2, >=1
// NumWays            8    DCACHE_SET_ASSOC; >=1
// TagWidth           44   DCACHE_TAG_WIDTH
// InvalidateOnFlush  1    1: clear valid+dirty; 0: clear dirty only, keep valid
// IdxW (local)            NumSets>1 ? $clog2(NumSets) : 1;  WayW (local) NumWays>1 ? $clog2(NumWays) : 1
// PORTS
// clk_i        in   1                 clock
// rst_i        in   1                 synchronous, active-high reset
// flush_req_i  in   1                 level; start a flush when idle
// flush_ack_o  out  1                 one-cycle pulse: flush complete
// busy_o       out  1                 high in every state except IDLE
// tag_req_o    out  1                 tag/state RAM read request
// tag_gnt_i    in   1                 read granted; data valid the following cycle
// tag_idx_o    out  IdxW              set index for read and update
// tag_rdata_i  in   NumWays*TagWidth  tags, way w at [w*TagWidth +: TagWidth]
// valid_i      in   NumWays           valid bits (cycle after grant)
// dirty_i      in   NumWays           dirty bits (cycle after grant)
// wb_req_o     out  1                 writeback request
// wb_gnt_i     in   1                 writeback accepted
// wb_tag_o     out  TagWidth          tag of line to write back
// wb_way_o     out  WayW              way of line to write back (set = tag_idx_o)
// upd_we_o     out  1                 state write strobe, all ways of set tag_idx_o
// upd_valid_o  out  NumWays           new valid bits
// upd_dirty_o  out  NumWays           new dirty bits (always '0)
// BEHAVIOUR
// - Reset: state IDLE, idx=0, pending mask=0; all outputs 0.
// - States: IDLE, READ_REQ, READ_WAIT, SCAN, UPDATE, DONE.
// - IDLE: flush_req_i=1 -> READ_REQ, idx=0. Otherwise stay.
// - READ_REQ: tag_req_o=1; tag_gnt_i=1 -> READ_WAIT, else hold request (idx stable).
// - READ_WAIT: capture tags, valid_i, pending = dirty_i & valid_i -> SCAN.
// - SCAN: pending!=0 -> wb_req_o=1 for lowest set bit w (wb_way_o=w, wb_tag_o=tag[w]);
//   wb_gnt_i=1 clears bit w; outputs stable while ungranted. pending==0 -> UPDATE (no req).
// - UPDATE: upd_we_o=1 one cycle; upd_valid_o = InvalidateOnFlush ? '0 : captured valid;
//   idx==NumSets-1 -> DONE, else idx+1 -> READ_REQ (no wrap beyond last set).
// - DONE: flush_ack_o=1 for exactly one cycle -> IDLE. flush_req_i still high in the next
//   IDLE cycle starts a new flush (controller drops the request on ack).
// - flush_req_i is ignored while busy_o=1; no abort path.
// - Latency (grants same-cycle): req sampled cycle 0 -> ack in cycle 4*NumSets+1,
//   +1 cycle per dirty valid line, +1 per stalled grant cycle.
// - Dirty but invalid ways are never written back.
// - tag_idx_o = idx in READ_REQ..UPDATE, 0 otherwise.
// - rst_i mid-flush: IDLE next cycle, no ack, no further req/update strobes.
// TESTING
// 1 NumSets=4, all clean, grants tied 1: flush_req at cycle 0 -> ack exactly cycle 17,
//   4 upd_we_o pulses idx 0..3, wb_req_o never high.
// 2 Set 2 dirty=8'b1000_0101, valid=8'hFF: wb ways 0,2,7 in order, tags match; ack at cycle 20.
// 3 dirty=8'h03, valid=8'h01: only way 0 written back; upd_valid_o=0 (Invalidate=1).
// 4 InvalidateOnFlush=0, valid=8'hF0: upd_valid_o=8'hF0, upd_dirty_o=0 per set.
// 5 tag_gnt_i/wb_gnt_i low 3 cycles: req held, tag_idx_o/wb_way_o/wb_tag_o stable, ack +6 cycles.
// 6 rst_i during SCAN of set 1: outputs 0 next cycle, no ack; new flush_req restarts at idx 0.

Source files
------------

// File: rtl/dcache_flush_sequencer_if.sv
// Flush sequencer bundle: controller handshake, tag/state RAM read and update, writeback port.
// Latency: none, pure signal grouping.
// Backpressure: tag_gnt_i and wb_gnt_i stall the sequencer; master drives, slave responds.
interface dcache_flush_sequencer_if #(
    parameter int NumSets  = 256,
    parameter int NumWays  = 8,
    parameter int TagWidth = 44
);
    localparam int IdxW = (NumSets > 1) ? $clog2(NumSets) : 1;
    localparam int WayW = (NumWays > 1) ? $clog2(NumWays) : 1;

    logic                         flush_req_i;
    logic                         flush_ack_o;
    logic                         busy_o;
    logic                         tag_req_o;
    logic                         tag_gnt_i;
    logic [IdxW-1:0]              tag_idx_o;
    logic [NumWays*TagWidth-1:0]  tag_rdata_i;
    logic [NumWays-1:0]           valid_i;
    logic [NumWays-1:0]           dirty_i;
    logic                         wb_req_o;
    logic                         wb_gnt_i;
    logic [TagWidth-1:0]          wb_tag_o;
    logic [WayW-1:0]              wb_way_o;
    logic                         upd_we_o;
    logic [NumWays-1:0]           upd_valid_o;
    logic [NumWays-1:0]           upd_dirty_o;

    modport master (
        input  flush_req_i, tag_gnt_i, tag_rdata_i, valid_i, dirty_i, wb_gnt_i,
        output flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_req_o, wb_tag_o, wb_way_o,
               upd_we_o, upd_valid_o, upd_dirty_o
    );

    modport slave (
        output flush_req_i, tag_gnt_i, tag_rdata_i, valid_i, dirty_i, wb_gnt_i,
        input  flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_req_o, wb_tag_o, wb_way_o,
               upd_we_o, upd_valid_o, upd_dirty_o
    );
endinterface

// File: rtl/dcache_flush_sequencer.sv
// Walks every cache set on flush: read tags/state, write back dirty valid lines, clear state.
// Latency: 4 cycles per set + 1 per dirty valid line + 1 for ack, plus any grant stall cycles.
// Backpressure: tag and writeback requests are held with stable payload until granted.
module dcache_flush_sequencer #(
    parameter int NumSets           = 256,
    parameter int NumWays           = 8,
    parameter int TagWidth          = 44,
    parameter bit InvalidateOnFlush = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dcache_flush_sequencer_if.master bus
);
    localparam int IdxW = (NumSets > 1) ? $clog2(NumSets) : 1;
    localparam int WayW = (NumWays > 1) ? $clog2(NumWays) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_WAIT,
        SCAN,
        UPDATE,
        DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [NumWays-1:0]          pend_q, pend_d;
    logic [NumWays-1:0]          valid_q, valid_d;
    logic [NumWays*TagWidth-1:0] tags_q, tags_d;

    logic [WayW-1:0]             sel_way;
    logic                        sel_found;

    // Pick the lowest-numbered way still waiting for writeback.
    always_comb begin
        sel_found = 1'b0;
        sel_way   = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (!sel_found && pend_q[w]) begin
                sel_found = 1'b1;
                sel_way   = WayW'(w);
            end
        end
    end

    // State register and captured set snapshot; reset abandons any flush in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            valid_q <= '0;
            tags_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            tags_q  <= tags_d;
        end
    end

    // Next-state and output decode; every output idles low outside its own state.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pend_d          = pend_q;
        valid_d         = valid_q;
        tags_d          = tags_q;

        bus.flush_ack_o = 1'b0;
        bus.busy_o      = (state_q != IDLE);
        bus.tag_req_o   = 1'b0;
        bus.tag_idx_o   = '0;
        bus.wb_req_o    = 1'b0;
        bus.wb_tag_o    = '0;
        bus.wb_way_o    = '0;
        bus.upd_we_o    = 1'b0;
        bus.upd_valid_o = '0;
        bus.upd_dirty_o = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.flush_req_i) begin
                    state_d = READ_REQ;
                    idx_d   = '0;
                end
            end
            READ_REQ: begin
                bus.tag_req_o = 1'b1;
                bus.tag_idx_o = idx_q;
                if (bus.tag_gnt_i) begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                // RAM data arrives one cycle after the grant; dirty-but-invalid lines are dropped here.
                bus.tag_idx_o = idx_q;
                tags_d        = bus.tag_rdata_i;
                valid_d       = bus.valid_i;
                pend_d        = bus.dirty_i & bus.valid_i;
                state_d       = SCAN;
            end
            SCAN: begin
                bus.tag_idx_o = idx_q;
                if (sel_found) begin
                    bus.wb_req_o = 1'b1;
                    bus.wb_way_o = sel_way;
                    bus.wb_tag_o = tags_q[int'(sel_way)*TagWidth +: TagWidth];
                    if (bus.wb_gnt_i) begin
                        pend_d = pend_q & ~(NumWays'(1) << sel_way);
                    end
                end else begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                bus.tag_idx_o   = idx_q;
                bus.upd_we_o    = 1'b1;
                bus.upd_valid_o = InvalidateOnFlush ? '0 : valid_q;
                if (idx_q == IdxW'(NumSets - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = READ_REQ;
                end
            end
            DONE: begin
                bus.flush_ack_o = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// Bench for the flush sequencer: invalidating and dirty-clearing instances driven in lockstep.
// Latency: checks ack cycle, writeback order/tags and per-set update strobes against hand values.
// Backpressure: hand sequences stall tag/writeback grants and reset mid-flush.
module tb_dcache_flush_sequencer;
    localparam int NS = 4;
    localparam int NW = 8;
    localparam int TW = 44;

    logic clk = 1'b0;
    logic rst;
    logic flush_req;
    logic tag_gnt;
    logic wb_gnt;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] m_dirty [NS];
    logic [7:0] m_valid [NS];

    always #5 clk = ~clk;

    dcache_flush_sequencer_if #(.NumSets(NS), .NumWays(NW), .TagWidth(TW)) ia ();
    dcache_flush_sequencer_if #(.NumSets(NS), .NumWays(NW), .TagWidth(TW)) ib ();

    dcache_flush_sequencer #(.NumSets(NS), .NumWays(NW), .TagWidth(TW), .InvalidateOnFlush(1'b1))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ia));
    dcache_flush_sequencer #(.NumSets(NS), .NumWays(NW), .TagWidth(TW), .InvalidateOnFlush(1'b0))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(ib));

    function automatic logic [TW-1:0] tag_of(input int s, input int w);
        return {20'hC0FFE, 8'(s), 8'(w), 8'(s * 8 + w + 1)};
    endfunction

    function automatic logic [NW*TW-1:0] tags_of(input int s);
        logic [NW*TW-1:0] r;
        r = '0;
        for (int w = 0; w < NW; w++) r[w*TW +: TW] = tag_of(s, w);
        return r;
    endfunction

    // RAM model: data only valid the cycle after a grant, all-ones garbage otherwise.
    logic       rd_vld_a, rd_vld_b;
    logic [1:0] rd_set_a, rd_set_b;
    always @(posedge clk) begin
        rd_vld_a <= !rst && ia.tag_req_o && ia.tag_gnt_i;
        rd_vld_b <= !rst && ib.tag_req_o && ib.tag_gnt_i;
        rd_set_a <= ia.tag_idx_o;
        rd_set_b <= ib.tag_idx_o;
    end

    assign ia.flush_req_i = flush_req;
    assign ib.flush_req_i = flush_req;
    assign ia.tag_gnt_i   = tag_gnt;
    assign ib.tag_gnt_i   = tag_gnt;
    assign ia.wb_gnt_i    = wb_gnt;
    assign ib.wb_gnt_i    = wb_gnt;
    assign ia.tag_rdata_i = rd_vld_a ? tags_of(int'(rd_set_a)) : '1;
    assign ib.tag_rdata_i = rd_vld_b ? tags_of(int'(rd_set_b)) : '1;
    assign ia.valid_i     = rd_vld_a ? m_valid[rd_set_a] : '1;
    assign ib.valid_i     = rd_vld_b ? m_valid[rd_set_b] : '1;
    assign ia.dirty_i     = rd_vld_a ? m_dirty[rd_set_a] : '1;
    assign ib.dirty_i     = rd_vld_b ? m_dirty[rd_set_b] : '1;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle: granted writebacks, update strobes, acks.
    int          wb_set_q [$];
    int          wb_way_q [$];
    logic [TW-1:0] wb_tag_q [$];
    int          upd_idx_q [$];
    logic [7:0]  upd_va_q [$];
    logic [7:0]  upd_da_q [$];
    logic [7:0]  upd_vb_q [$];
    logic [7:0]  upd_db_q [$];
    int          ack_a_q [$];
    int          ack_b_q [$];
    always @(negedge clk) begin
        if (ia.wb_req_o && ia.wb_gnt_i) begin
            wb_set_q.push_back(int'(ia.tag_idx_o));
            wb_way_q.push_back(int'(ia.wb_way_o));
            wb_tag_q.push_back(ia.wb_tag_o);
        end
        if (ia.upd_we_o) begin
            upd_idx_q.push_back(int'(ia.tag_idx_o));
            upd_va_q.push_back(ia.upd_valid_o);
            upd_da_q.push_back(ia.upd_dirty_o);
        end
        if (ib.upd_we_o) begin
            upd_vb_q.push_back(ib.upd_valid_o);
            upd_db_q.push_back(ib.upd_dirty_o);
        end
        if (ia.flush_ack_o) ack_a_q.push_back(cyc);
        if (ib.flush_ack_o) ack_b_q.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] d, input logic [31:0] v);
        for (int s = 0; s < NS; s++) begin
            m_dirty[s] = d[s*8 +: 8];
            m_valid[s] = v[s*8 +: 8];
        end
    endtask

    task automatic chk_all_low(input string nm);
        chk({nm, ".busy"},    {63'd0, ia.busy_o},      64'd0);
        chk({nm, ".tag_req"}, {63'd0, ia.tag_req_o},   64'd0);
        chk({nm, ".wb_req"},  {63'd0, ia.wb_req_o},    64'd0);
        chk({nm, ".upd_we"},  {63'd0, ia.upd_we_o},    64'd0);
        chk({nm, ".ack"},     {63'd0, ia.flush_ack_o}, 64'd0);
        chk({nm, ".tag_idx"}, 64'(ia.tag_idx_o),       64'd0);
        chk({nm, ".b_busy"},  {63'd0, ib.busy_o},      64'd0);
    endtask

    // Full flush with grants tied high; memory must already be loaded.
    task automatic run_flush(input string nm, input int exp_lat, input int exp_nwb);
        int wb0, u0, a0, b0, start, k;
        wb0 = wb_way_q.size();
        u0  = upd_idx_q.size();
        a0  = ack_a_q.size();
        b0  = ack_b_q.size();
        @(negedge clk);
        flush_req = 1'b1;
        start     = cyc;
        @(negedge clk);
        flush_req = 1'b0;
        chk({nm, ".busy1"},    {63'd0, ia.busy_o},    64'd1);
        chk({nm, ".first_req"}, {63'd0, ia.tag_req_o}, 64'd1);
        chk({nm, ".first_idx"}, 64'(ia.tag_idx_o),     64'd0);
        for (int i = 0; i < 400 && ack_a_q.size() == a0; i++) @(negedge clk);
        if (ack_a_q.size() == a0) begin
            chk({nm, ".ack_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({nm, ".lat_a"}, 64'(ack_a_q[a0] - start), 64'(exp_lat));
        if (ack_b_q.size() > b0) chk({nm, ".lat_b"}, 64'(ack_b_q[b0] - start), 64'(exp_lat));
        else chk({nm, ".ack_b"}, 64'd0, 64'd1);
        chk({nm, ".nwb"}, 64'(wb_way_q.size() - wb0), 64'(exp_nwb));
        k = wb0;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                if (m_dirty[s][w] && m_valid[s][w]) begin
                    if (k < wb_way_q.size()) begin
                        chk({nm, ".wb_set"}, 64'(wb_set_q[k]), 64'(s));
                        chk({nm, ".wb_way"}, 64'(wb_way_q[k]), 64'(w));
                        chk({nm, ".wb_tag"}, 64'(wb_tag_q[k]), 64'(tag_of(s, w)));
                    end
                    k++;
                end
            end
        end
        chk({nm, ".nupd"}, 64'(upd_idx_q.size() - u0), 64'(NS));
        for (int s = 0; s < NS; s++) begin
            if (u0 + s < upd_idx_q.size() && u0 + s < upd_vb_q.size()) begin
                chk({nm, ".upd_idx"},   64'(upd_idx_q[u0+s]), 64'(s));
                chk({nm, ".upd_va"},    64'(upd_va_q[u0+s]),  64'd0);
                chk({nm, ".upd_da"},    64'(upd_da_q[u0+s]),  64'd0);
                chk({nm, ".upd_vb"},    64'(upd_vb_q[u0+s]),  64'(m_valid[s]));
                chk({nm, ".upd_db"},    64'(upd_db_q[u0+s]),  64'd0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk({nm, ".one_ack"}, 64'(ack_a_q.size() - a0), 64'd1);
        chk({nm, ".idle"},    {63'd0, ia.busy_o},        64'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] dirty;
        logic [31:0] valid;
        int          exp_lat;
        int          exp_nwb;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int start, a0, wb0, u0, n;

        vecs[0] = '{"clean",        32'h0000_0000, 32'hFFFF_FFFF, 17, 0};
        vecs[1] = '{"set2_85",      32'h0085_0000, 32'hFFFF_FFFF, 20, 3};
        vecs[2] = '{"dirty_inval",  32'h0000_0300, 32'h0000_0100, 18, 1};
        vecs[3] = '{"keep_valid",   32'hC000_0010, 32'hF0F0_F0F0, 20, 3};
        vecs[4] = '{"all_dirty",    32'h0000_00FF, 32'hFFFF_FFFF, 25, 8};
        vecs[5] = '{"no_valid",     32'hFF00_0000, 32'h00FF_FFFF, 17, 0};

        rst       = 1'b1;
        flush_req = 1'b0;
        tag_gnt   = 1'b1;
        wb_gnt    = 1'b1;
        load_mem(32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_low("reset");
        chk("reset.upd_valid", 64'(ib.upd_valid_o), 64'd0);

        for (int v = 0; v < 6; v++) begin
            load_mem(vecs[v].dirty, vecs[v].valid);
            run_flush(vecs[v].name, vecs[v].exp_lat, vecs[v].exp_nwb);
        end

        // Grant stalls: 3 cycles on the first tag read, 3 on the only writeback.
        load_mem(32'h0001_0000, 32'hFFFF_FFFF);
        a0  = ack_a_q.size();
        wb0 = wb_way_q.size();
        @(negedge clk);
        tag_gnt   = 1'b0;
        wb_gnt    = 1'b0;
        flush_req = 1'b1;
        start     = cyc;
        @(negedge clk);
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall.tag_req", {63'd0, ia.tag_req_o}, 64'd1);
            chk("stall.tag_idx", 64'(ia.tag_idx_o),     64'd0);
            if (i < 3) @(negedge clk);
        end
        tag_gnt = 1'b1;
        n = 0;
        while (n < 100 && !ia.wb_req_o) begin
            @(negedge clk);
            n++;
        end
        chk("stall.wb_seen", {63'd0, ia.wb_req_o}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("stall.wb_req", {63'd0, ia.wb_req_o}, 64'd1);
            chk("stall.wb_way", 64'(ia.wb_way_o),     64'd0);
            chk("stall.wb_tag", 64'(ia.wb_tag_o),     64'(tag_of(2, 0)));
            chk("stall.wb_idx", 64'(ia.tag_idx_o),    64'd2);
            if (i < 3) @(negedge clk);
        end
        wb_gnt = 1'b1;
        for (int i = 0; i < 400 && ack_a_q.size() == a0; i++) @(negedge clk);
        if (ack_a_q.size() == a0) chk("stall.ack_timeout", 64'd0, 64'd1);
        else chk("stall.lat", 64'(ack_a_q[a0] - start), 64'd24);
        chk("stall.nwb", 64'(wb_way_q.size() - wb0), 64'd1);

        // Reset while set 1 is waiting on a writeback grant.
        load_mem(32'h0000_0100, 32'h0000_0100);
        a0 = ack_a_q.size();
        u0 = upd_idx_q.size();
        @(negedge clk);
        wb_gnt    = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        n = 0;
        while (n < 100 && !(ia.wb_req_o && ia.tag_idx_o == 2'd1)) begin
            @(negedge clk);
            n++;
        end
        chk("rst.in_scan", {63'd0, ia.wb_req_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_low("rst");
        rst    = 1'b0;
        wb_gnt = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst.no_ack", 64'(ack_a_q.size() - a0),   64'd0);
        chk("rst.no_upd", 64'(upd_idx_q.size() - u0), 64'd1);
        chk("rst.idle",   {63'd0, ia.busy_o},         64'd0);
        run_flush("restart", 18, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
